// File: rtl/alu_op_decoder_pkg.sv
// Shared ALU control encodings: ALUop codes, operand-select codes, MIPS
// opcode/funct fields and the decoded-control record. The ALU imports the
// same package, so every code here means exactly one thing on both sides.
package alu_op_decoder_pkg;

    // ALU operation codes
    localparam logic [3:0] ALU_EQ   = 4'd0;
    localparam logic [3:0] ALU_NE   = 4'd1;
    localparam logic [3:0] ALU_LT   = 4'd2;
    localparam logic [3:0] ALU_LTU  = 4'd3;
    localparam logic [3:0] ALU_GT   = 4'd4;
    localparam logic [3:0] ALU_GTU  = 4'd5;
    localparam logic [3:0] ALU_ADD  = 4'd6;
    localparam logic [3:0] ALU_PASS = 4'd7;
    localparam logic [3:0] ALU_XOR  = 4'd8;
    localparam logic [3:0] ALU_OR   = 4'd9;
    localparam logic [3:0] ALU_AND  = 4'd10;
    localparam logic [3:0] ALU_SLL  = 4'd11;
    localparam logic [3:0] ALU_SRA  = 4'd12;
    localparam logic [3:0] ALU_SRL  = 4'd13;
    localparam logic [3:0] ALU_SUB  = 4'd14;
    localparam logic [3:0] ALU_NOP  = 4'd15;

    // A operand select
    localparam logic ASEL_RS = 1'b0;
    localparam logic ASEL_RT = 1'b1;

    // B operand select
    localparam logic [2:0] BSEL_RT    = 3'd0;
    localparam logic [2:0] BSEL_SEXT  = 3'd1;
    localparam logic [2:0] BSEL_ZEXT  = 3'd2;
    localparam logic [2:0] BSEL_LUI   = 3'd3;
    localparam logic [2:0] BSEL_SHAMT = 3'd4;
    localparam logic [2:0] BSEL_ZERO  = 3'd5;
    localparam logic [2:0] BSEL_RS    = 3'd6;

    // Primary opcodes
    localparam logic [5:0] OP_RTYPE  = 6'h00;
    localparam logic [5:0] OP_REGIMM = 6'h01;
    localparam logic [5:0] OP_J      = 6'h02;
    localparam logic [5:0] OP_JAL    = 6'h03;
    localparam logic [5:0] OP_BEQ    = 6'h04;
    localparam logic [5:0] OP_BNE    = 6'h05;
    localparam logic [5:0] OP_BLEZ   = 6'h06;
    localparam logic [5:0] OP_BGTZ   = 6'h07;
    localparam logic [5:0] OP_ADDIU  = 6'h09;
    localparam logic [5:0] OP_SLTI   = 6'h0A;
    localparam logic [5:0] OP_SLTIU  = 6'h0B;
    localparam logic [5:0] OP_ANDI   = 6'h0C;
    localparam logic [5:0] OP_ORI    = 6'h0D;
    localparam logic [5:0] OP_XORI   = 6'h0E;
    localparam logic [5:0] OP_LUI    = 6'h0F;
    localparam logic [5:0] OP_LB     = 6'h20;
    localparam logic [5:0] OP_LH     = 6'h21;
    localparam logic [5:0] OP_LW     = 6'h23;
    localparam logic [5:0] OP_LBU    = 6'h24;
    localparam logic [5:0] OP_LHU    = 6'h25;
    localparam logic [5:0] OP_SB     = 6'h28;
    localparam logic [5:0] OP_SH     = 6'h29;
    localparam logic [5:0] OP_SW     = 6'h2B;

    // R-type funct codes
    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_SLLV = 6'h04;
    localparam logic [5:0] FN_SRLV = 6'h06;
    localparam logic [5:0] FN_SRAV = 6'h07;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_JALR = 6'h09;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2A;
    localparam logic [5:0] FN_SLTU = 6'h2B;

    // REGIMM rt field selects the branch flavour
    localparam logic [4:0] RT_BLTZ = 5'd0;
    localparam logic [4:0] RT_BGEZ = 5'd1;

    typedef struct packed {
        logic [3:0] aluop;
        logic       a_sel;
        logic [2:0] b_sel;
        logic       invert;
        logic       illegal;
    } alu_ctrl_t;

    typedef struct packed {
        alu_ctrl_t   ctrl;
        logic [31:0] instr;
    } skid_entry_t;

    localparam alu_ctrl_t CTRL_ILLEGAL = '{aluop: ALU_NOP, a_sel: ASEL_RS,
                                           b_sel: BSEL_RT, invert: 1'b0,
                                           illegal: 1'b1};
    localparam alu_ctrl_t CTRL_IDLE    = '{aluop: ALU_NOP, a_sel: ASEL_RS,
                                           b_sel: BSEL_RT, invert: 1'b0,
                                           illegal: 1'b0};
    localparam skid_entry_t ENTRY_IDLE = '{ctrl: CTRL_IDLE, instr: 32'h0};

    // Build a legal control record
    function automatic alu_ctrl_t make_ctrl(input logic [3:0] aluop,
                                            input logic       a_sel,
                                            input logic [2:0] b_sel,
                                            input logic       invert);
        alu_ctrl_t c;
        c.aluop   = aluop;
        c.a_sel   = a_sel;
        c.b_sel   = b_sel;
        c.invert  = invert;
        c.illegal = 1'b0;
        return c;
    endfunction

endpackage

// File: rtl/alu_op_decode_comb.sv
// Purely combinational MIPS150 instruction -> ALU control decode.
// Only the opcode, funct and rt fields steer the decode; anything not
// recognised comes out as an illegal NOP.
module alu_op_decode_comb
    import alu_op_decoder_pkg::*;
(
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic [4:0] rt,
    output alu_ctrl_t  ctrl
);

    // R-type decode by funct; shifts take the shifted value from rt
    alu_ctrl_t rtype_ctrl;
    always_comb begin
        rtype_ctrl = CTRL_ILLEGAL;
        case (funct)
            FN_SLL:  rtype_ctrl = make_ctrl(ALU_SLL, ASEL_RT, BSEL_SHAMT, 1'b0);
            FN_SRL:  rtype_ctrl = make_ctrl(ALU_SRL, ASEL_RT, BSEL_SHAMT, 1'b0);
            FN_SRA:  rtype_ctrl = make_ctrl(ALU_SRA, ASEL_RT, BSEL_SHAMT, 1'b0);
            FN_SLLV: rtype_ctrl = make_ctrl(ALU_SLL, ASEL_RT, BSEL_RS,    1'b0);
            FN_SRLV: rtype_ctrl = make_ctrl(ALU_SRL, ASEL_RT, BSEL_RS,    1'b0);
            FN_SRAV: rtype_ctrl = make_ctrl(ALU_SRA, ASEL_RT, BSEL_RS,    1'b0);
            FN_JR,
            FN_JALR: rtype_ctrl = make_ctrl(ALU_NOP, ASEL_RS, BSEL_RT,    1'b0);
            FN_ADDU: rtype_ctrl = make_ctrl(ALU_ADD, ASEL_RS, BSEL_RT,    1'b0);
            FN_SUBU: rtype_ctrl = make_ctrl(ALU_SUB, ASEL_RS, BSEL_RT,    1'b0);
            FN_AND:  rtype_ctrl = make_ctrl(ALU_AND, ASEL_RS, BSEL_RT,    1'b0);
            FN_OR:   rtype_ctrl = make_ctrl(ALU_OR,  ASEL_RS, BSEL_RT,    1'b0);
            FN_XOR:  rtype_ctrl = make_ctrl(ALU_XOR, ASEL_RS, BSEL_RT,    1'b0);
            FN_NOR:  rtype_ctrl = make_ctrl(ALU_OR,  ASEL_RS, BSEL_RT,    1'b1);
            FN_SLT:  rtype_ctrl = make_ctrl(ALU_LT,  ASEL_RS, BSEL_RT,    1'b0);
            FN_SLTU: rtype_ctrl = make_ctrl(ALU_LTU, ASEL_RS, BSEL_RT,    1'b0);
            default: rtype_ctrl = CTRL_ILLEGAL;
        endcase
    end

    // REGIMM branches compare rs against zero; BGEZ is the inverted BLTZ
    alu_ctrl_t regimm_ctrl;
    always_comb begin
        regimm_ctrl = CTRL_ILLEGAL;
        case (rt)
            RT_BLTZ: regimm_ctrl = make_ctrl(ALU_LT, ASEL_RS, BSEL_ZERO, 1'b0);
            RT_BGEZ: regimm_ctrl = make_ctrl(ALU_LT, ASEL_RS, BSEL_ZERO, 1'b1);
            default: regimm_ctrl = CTRL_ILLEGAL;
        endcase
    end

    // Primary opcode decode
    always_comb begin
        ctrl = CTRL_ILLEGAL;
        case (opcode)
            OP_RTYPE:  ctrl = rtype_ctrl;
            OP_REGIMM: ctrl = regimm_ctrl;
            OP_J,
            OP_JAL:    ctrl = make_ctrl(ALU_NOP,  ASEL_RS, BSEL_RT,   1'b0);
            OP_BEQ:    ctrl = make_ctrl(ALU_EQ,   ASEL_RS, BSEL_RT,   1'b0);
            OP_BNE:    ctrl = make_ctrl(ALU_NE,   ASEL_RS, BSEL_RT,   1'b0);
            // BLEZ is !(rs > 0)
            OP_BLEZ:   ctrl = make_ctrl(ALU_GT,   ASEL_RS, BSEL_ZERO, 1'b1);
            OP_BGTZ:   ctrl = make_ctrl(ALU_GT,   ASEL_RS, BSEL_ZERO, 1'b0);
            OP_ADDIU:  ctrl = make_ctrl(ALU_ADD,  ASEL_RS, BSEL_SEXT, 1'b0);
            OP_SLTI:   ctrl = make_ctrl(ALU_LT,   ASEL_RS, BSEL_SEXT, 1'b0);
            // SLTIU sign-extends the immediate, then compares unsigned
            OP_SLTIU:  ctrl = make_ctrl(ALU_LTU,  ASEL_RS, BSEL_SEXT, 1'b0);
            OP_ANDI:   ctrl = make_ctrl(ALU_AND,  ASEL_RS, BSEL_ZEXT, 1'b0);
            OP_ORI:    ctrl = make_ctrl(ALU_OR,   ASEL_RS, BSEL_ZEXT, 1'b0);
            OP_XORI:   ctrl = make_ctrl(ALU_XOR,  ASEL_RS, BSEL_ZEXT, 1'b0);
            OP_LUI:    ctrl = make_ctrl(ALU_PASS, ASEL_RS, BSEL_LUI,  1'b0);
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW:
                       ctrl = make_ctrl(ALU_ADD,  ASEL_RS, BSEL_SEXT, 1'b0);
            default:   ctrl = CTRL_ILLEGAL;
        endcase
    end

endmodule

// File: rtl/alu_op_decoder.sv
// Decode stage feeding the ALU: decodes each accepted instruction and holds
// the results in a 2-entry FIFO skid buffer. in_ready depends only on the
// registered fill level, so there is no combinational path from out_ready.
module alu_op_decoder
    import alu_op_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_aluop,
    output logic        out_a_sel,
    output logic [2:0]  out_b_sel,
    output logic        out_invert,
    output logic        out_illegal,
    output logic [31:0] out_instr
);

    alu_ctrl_t   dec_ctrl;
    skid_entry_t new_entry;
    skid_entry_t head_q;
    skid_entry_t tail_q;
    logic [1:0]  count_q;
    logic        push;
    logic        pop;

    alu_op_decode_comb u_decode (
        .opcode (in_instr[31:26]),
        .funct  (in_instr[5:0]),
        .rt     (in_instr[20:16]),
        .ctrl   (dec_ctrl)
    );

    // Handshake qualifiers and the entry that would be written on accept
    always_comb begin
        in_ready        = (count_q != 2'd2);
        out_valid       = (count_q != 2'd0);
        push            = in_valid & in_ready;
        pop             = out_valid & out_ready;
        new_entry.ctrl  = dec_ctrl;
        new_entry.instr = in_instr;
    end

    // Fill level; flush wins over every push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= 2'd0;
        end else if (flush) begin
            count_q <= 2'd0;
        end else begin
            case ({push, pop})
                2'b10:   count_q <= count_q + 2'd1;
                2'b01:   count_q <= count_q - 2'd1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entry storage: head is what execute sees, tail is the skid slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q <= ENTRY_IDLE;
            tail_q <= ENTRY_IDLE;
        end else if (!flush) begin
            case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= new_entry;
                    end else begin
                        tail_q <= new_entry;
                    end
                end
                2'b01: begin
                    head_q <= tail_q;
                end
                2'b11: begin
                    // Only reachable at count 1 (count 2 blocks push,
                    // count 0 blocks pop): new entry replaces the head.
                    head_q <= new_entry;
                end
                default: begin
                    head_q <= head_q;
                end
            endcase
        end
    end

    // Present the head entry
    always_comb begin
        out_aluop   = head_q.ctrl.aluop;
        out_a_sel   = head_q.ctrl.a_sel;
        out_b_sel   = head_q.ctrl.b_sel;
        out_invert  = head_q.ctrl.invert;
        out_illegal = head_q.ctrl.illegal;
        out_instr   = head_q.instr;
    end

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed bench for alu_op_decoder with a scoreboard queue of expected
// output entries {aluop, a_sel, b_sel, invert, illegal, instr}.
module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [3:0]  out_aluop;
    logic        out_a_sel;
    logic [2:0]  out_b_sel;
    logic        out_invert;
    logic        out_illegal;
    logic [31:0] out_instr;

    int checks = 0;
    int passed = 0;
    logic [41:0] sb[$];

    alu_op_decoder dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_instr    (in_instr),
        .flush       (flush),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_aluop   (out_aluop),
        .out_a_sel   (out_a_sel),
        .out_b_sel   (out_b_sel),
        .out_invert  (out_invert),
        .out_illegal (out_illegal),
        .out_instr   (out_instr)
    );

    always #5 clk = ~clk;

    function automatic logic [41:0] ex(input logic [31:0] i, input int op,
                                       input int a, input int b,
                                       input int inv, input int ill);
        return {op[3:0], a[0], b[2:0], inv[0], ill[0], i};
    endfunction

    function automatic logic [41:0] observed();
        return {out_aluop, out_a_sel, out_b_sel, out_invert, out_illegal, out_instr};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Waits (bounded) for the offered word to be accepted, records it
    task automatic wait_accept(input logic [41:0] exp, output int stalls);
        int n = 0;
        @(negedge clk);
        while (!in_ready && n < 40) begin
            n++;
            @(negedge clk);
        end
        check("accept_in_time", 64'(n < 40), 64'd1);
        if (in_ready) sb.push_back(exp);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        stalls = n;
    endtask

    task automatic send(input logic [41:0] exp, output int stalls);
        in_valid = 1'b1;
        in_instr = exp[31:0];
        wait_accept(exp, stalls);
    endtask

    // Scoreboard: every handshake that will complete at the next edge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n && out_valid && out_ready && !flush) begin
                check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) check("out_entry", 64'(observed()), 64'(sb.pop_front()));
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int st;
        int total_st;
        logic [41:0] e_a, e_b, e_c, e_x, e_y, e_z, e_w;
        logic [41:0] stream[$];

        rst_n = 1'b0; in_valid = 1'b0; in_instr = 32'h0;
        flush = 1'b0; out_ready = 1'b0;
        #12;
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_in_ready",  64'(in_ready),  64'd1);
        check("reset_fields", 64'(observed()), 64'(ex(32'h0, 15, 0, 0, 0, 0)));
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_reset_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        // First-accept latency with the execute stage stalled
        e_a = ex(32'h00851021, 6, 0, 0, 0, 0);
        send(e_a, st);
        check("latency_out_valid", 64'(out_valid), 64'd1);
        check("addu_fields", 64'(observed()), 64'(e_a));
        out_ready = 1'b1;
        @(posedge clk); #1;

        // Decode table, streamed back to back
        stream.push_back(ex(32'h3C011234, 7, 0, 3, 0, 0));   // LUI
        stream.push_back(ex(32'h00031083, 12, 1, 4, 0, 0));  // SRA
        stream.push_back(ex(32'h00031082, 13, 1, 4, 0, 0));  // SRL
        stream.push_back(ex(32'h00851027, 9, 0, 0, 1, 0));   // NOR
        stream.push_back(ex(32'h18800003, 4, 0, 5, 1, 0));   // BLEZ
        stream.push_back(ex(32'h1C800003, 4, 0, 5, 0, 0));   // BGTZ
        stream.push_back(ex(32'h04820005, 15, 0, 0, 0, 1));  // REGIMM rt=2
        stream.push_back(ex(32'h04800003, 2, 0, 5, 0, 0));   // BLTZ
        stream.push_back(ex(32'h04810004, 2, 0, 5, 1, 0));   // BGEZ
        stream.push_back(ex(32'h00851004, 11, 1, 6, 0, 0));  // SLLV
        stream.push_back(ex(32'h2C850010, 3, 0, 1, 0, 0));   // SLTIU
        stream.push_back(ex(32'h34850010, 9, 0, 2, 0, 0));   // ORI
        stream.push_back(ex(32'h8C850000, 6, 0, 1, 0, 0));   // LW
        stream.push_back(ex(32'hAC850000, 6, 0, 1, 0, 0));   // SW
        stream.push_back(ex(32'h08000010, 15, 0, 0, 0, 0));  // J
        stream.push_back(ex(32'h03E00008, 15, 0, 0, 0, 0));  // JR
        stream.push_back(ex(32'h00851023, 14, 0, 0, 0, 0));  // SUBU
        stream.push_back(ex(32'h0085102A, 2, 0, 0, 0, 0));   // SLT
        stream.push_back(ex(32'h14850002, 1, 0, 0, 0, 0));   // BNE
        stream.push_back(ex(32'h10850002, 0, 0, 0, 0, 0));   // BEQ
        stream.push_back(ex(32'hFC000000, 15, 0, 0, 0, 1));  // bad opcode
        stream.push_back(ex(32'h00000001, 15, 0, 0, 0, 1));  // bad funct
        total_st = 0;
        foreach (stream[k]) begin
            send(stream[k], st);
            total_st += st;
        end
        check("stream_no_stall", 64'(total_st), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        check("stream_drained", 64'(sb.size()), 64'd0);

        // Backpressure: two fill the buffer, the third waits
        out_ready = 1'b0;
        e_a = ex(32'h00851025, 9, 0, 0, 0, 0);   // OR
        e_b = ex(32'h00851026, 8, 0, 0, 0, 0);   // XOR
        e_c = ex(32'h3085FFFF, 10, 0, 2, 0, 0);  // ANDI
        send(e_a, st);
        send(e_b, st);
        in_valid = 1'b1;
        in_instr = e_c[31:0];
        repeat (3) begin
            @(negedge clk);
            check("full_in_ready", 64'(in_ready), 64'd0);
            check("held_head", 64'(observed()), 64'(e_a));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(negedge clk);
        check("no_comb_ready", 64'(in_ready), 64'd0);
        wait_accept(e_c, st);
        repeat (3) @(posedge clk);
        #1;
        check("bp_drained", 64'(sb.size()), 64'd0);

        // Flush at count 2 with a same-cycle offer
        out_ready = 1'b0;
        e_x = ex(32'h24850007, 6, 0, 1, 0, 0);   // ADDIU
        e_y = ex(32'h28850007, 2, 0, 1, 0, 0);   // SLTI
        e_z = ex(32'h38850007, 8, 0, 2, 0, 0);   // XORI
        send(e_x, st);
        send(e_y, st);
        in_valid = 1'b1;
        in_instr = e_z[31:0];
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        in_valid = 1'b0;
        sb.delete();
        @(negedge clk);
        check("flush_out_valid", 64'(out_valid), 64'd0);
        check("flush_in_ready",  64'(in_ready),  64'd1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        e_w = ex(32'h0C000004, 15, 0, 0, 0, 0);  // JAL
        send(e_w, st);
        repeat (3) @(posedge clk);
        #1;
        check("flush_drained", 64'(sb.size()), 64'd0);

        // Asynchronous reset in the middle of a transfer
        out_ready = 1'b0;
        send(ex(32'h00851024, 10, 0, 0, 0, 0), st);  // AND
        in_valid = 1'b1;
        in_instr = 32'h0085102B;
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_out_valid", 64'(out_valid), 64'd0);
        check("mid_reset_in_ready",  64'(in_ready),  64'd1);
        check("mid_reset_fields", 64'(observed()), 64'(ex(32'h0, 15, 0, 0, 0, 0)));
        sb.delete();
        in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        out_ready = 1'b1;
        send(ex(32'h0085102B, 3, 0, 0, 0, 0), st);   // SLTU
        repeat (3) @(posedge clk);
        #1;
        check("final_drained", 64'(sb.size()), 64'd0);
        check("final_out_valid", 64'(out_valid), 64'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
